// File: rtl/mul_add_seq.sv
// Sequential shift-add reconstructor: P = Q*D + R, one partial product per clock.
// Optional remainder consistency flag (rem_err) enabled by defining MULADD_REMCHK_EN.
module mul_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   D,
  input  logic [WIDTH-1:0]   R,
  output logic [2*WIDTH-1:0] P,
  output logic               ovf,
`ifdef MULADD_REMCHK_EN
  output logic               rem_err,
`endif
  output logic               busy,
  output logic               done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] p_reg, p_next;
  logic               ovf_reg, ovf_next;
  logic               done_reg, done_next;
`ifdef MULADD_REMCHK_EN
  logic               remp_reg, remp_next;
  logic               rem_err_reg, rem_err_next;
`endif

  // The done cycle still counts as busy, so a start there is ignored.
  logic accept;
  assign accept = start && (state_reg == IDLE) && !done_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      p_reg       <= '0;
      ovf_reg     <= 1'b0;
      done_reg    <= 1'b0;
`ifdef MULADD_REMCHK_EN
      remp_reg    <= 1'b0;
      rem_err_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      cnt_reg     <= cnt_next;
      p_reg       <= p_next;
      ovf_reg     <= ovf_next;
      done_reg    <= done_next;
`ifdef MULADD_REMCHK_EN
      remp_reg    <= remp_next;
      rem_err_reg <= rem_err_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    cnt_next     = cnt_reg;
    p_next       = p_reg;
    ovf_next     = ovf_reg;
    done_next    = 1'b0;
`ifdef MULADD_REMCHK_EN
    remp_next    = remp_reg;
    rem_err_next = rem_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
          acc_next    = {{WIDTH{1'b0}}, R};
          mcand_next  = {{WIDTH{1'b0}}, D};
          mplier_next = Q;
          cnt_next    = '0;
          state_next  = RUN;
`ifdef MULADD_REMCHK_EN
          remp_next   = (R >= D);
`endif
        end
      end
      RUN: begin
        if (mplier_reg[0]) begin
          acc_next = acc_reg + mcand_reg;
        end
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        p_next       = acc_reg;
        ovf_next     = |acc_reg[2*WIDTH-1:WIDTH];
        done_next    = 1'b1;
        state_next   = IDLE;
`ifdef MULADD_REMCHK_EN
        rem_err_next = remp_reg;
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign P    = p_reg;
  assign ovf  = ovf_reg;
  assign done = done_reg;
  assign busy = (state_reg != IDLE) || done_reg;
`ifdef MULADD_REMCHK_EN
  assign rem_err = rem_err_reg;
`endif

endmodule
